// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame size, keyboard
// command bytes and the odd-parity helper used to build a frame.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line, plus falling-edge detect on the
// synchronized level. Shared by the host transmitter and the keyboard receiver.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Idle bus level is high; resetting to 1 avoids a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make this a true shift chain;
            // blocking ones would collapse both stages into a single flop.
            sync_q <= {sync_q[0], line_i};
            prev_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign fall_o  = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one
// byte on device clock edges, collect the ACK. Define PS2_TX_RETRY_EN to retry
// on NACK/timeout up to MAX_RETRY extra attempts.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SHIFT_W = PS2_FRAME_BITS - 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         LAST_EDGE    = 4'(SHIFT_W - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    ps2_tx_state_e      state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [7:0]         byte_q, byte_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               data_oe_q, data_oe_d;
    logic               nack_flag_q, nack_flag_d;
    logic               done_q, done_d;
    logic               nack_q, nack_d;
    logic               timeout_q, timeout_d;

    logic clk_level, clk_fall, data_level, data_fall_unused;
    logic expire, finish, retry_ok;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    // Data-line edges matter only to the receiver.
    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data_in),
        .level_o (data_level),
        .fall_o  (data_fall_unused)
    );

    assign retry_ok = RETRY_EN && (retry_q < RETRY_LIMIT);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        retry_d     = retry_q;
        data_oe_d   = data_oe_q;
        nack_flag_d = nack_flag_q;
        done_d      = 1'b0;
        nack_d      = 1'b0;
        timeout_d   = 1'b0;
        expire      = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    byte_d  = tx_data;
                    shift_d = {1'b1, odd_parity(tx_data), tx_data};
                    cnt_d   = '0;
                    retry_d = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) state_d = RTS;
                else                       cnt_d   = cnt_q + CNT_W'(1);
            end
            RTS: begin
                data_oe_d = 1'b1;
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    data_oe_d = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_EDGE) state_d = WAIT_ACK;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    expire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_ACK: begin
                if (clk_fall) begin
                    cnt_d       = '0;
                    nack_flag_d = data_level;
                    state_d     = WAIT_IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    expire = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level)        finish = 1'b1;
                else if (clk_fall)                  cnt_d  = '0;
                else if (cnt_q == TIMEOUT_LAST)     expire = 1'b1;
                else                                cnt_d  = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // A failed attempt restarts from INHIBIT while retries remain;
        // only the final outcome is reported.
        if ((expire || (finish && nack_flag_q)) && retry_ok) begin
            retry_d = retry_q + RETRY_W'(1);
            shift_d = {1'b1, odd_parity(byte_q), byte_q};
            cnt_d   = '0;
            state_d = INHIBIT;
        end else if (expire) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
        end else if (finish) begin
            done_d  = 1'b1;
            nack_d  = nack_flag_q;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            byte_q      <= '0;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            retry_q     <= '0;
            data_oe_q   <= 1'b0;
            nack_flag_q <= 1'b0;
            done_q      <= 1'b0;
            nack_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            retry_q     <= retry_d;
            data_oe_q   <= data_oe_d;
            nack_flag_q <= nack_flag_d;
            done_q      <= done_d;
            nack_q      <= nack_d;
            timeout_q   <= timeout_d;
        end
    end

    // Line enables decode from state so leaving RTS/SEND releases them at once.
    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == RTS);
    assign ps2_data_oe = (state_q == RTS) || ((state_q == SEND) && data_oe_q);
    assign done        = done_q;
    assign nack        = nack_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural PS/2 device clocks the
// frame out, and expected frames come from an arithmetic model of the byte.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 60;
    localparam int TMO  = 3000;
    localparam int MAXR = 2;
    localparam int HALF = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk, dev_data;

    // Open-drain bus: either side may pull a line low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (MAXR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .nack        (nack),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus activity monitor, sampled on the inactive edge.
    int   cyc = 0, inhib_cyc = 0, rts_cyc = 0, phases = 0;
    int   done_cnt = 0, to_cnt = 0, last_rts = 0, last_to = 0;
    logic clk_oe_prev = 1'b0;

    always @(negedge clk) begin
        cyc         <= cyc + 1;
        clk_oe_prev <= ps2_clk_oe;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inhib_cyc <= inhib_cyc + 1;
        if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) begin
            rts_cyc  <= rts_cyc + 1;
            last_rts <= cyc;
        end
        if (ps2_clk_oe === 1'b1 && clk_oe_prev === 1'b0) phases <= phases + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (timeout === 1'b1) begin
            to_cnt  <= to_cnt + 1;
            last_to <= cyc;
        end
    end

    // Reference frame: bits as a device receives them after the start bit.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int i = 0; i < 8; i++) f[i] = 1'((b >> i) & 8'd1);
        f[8] = ($countones(b) % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_send_entry(output bit got);
        got = 1'b0;
        for (int i = 0; i < INH + 100; i++) begin
            @(negedge clk);
            if (ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic dev_pulse(output logic sampled);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        sampled = ps2_data_in;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic device_frame(input bit ack, output bit got, output logic start,
                                output logic [9:0] bits);
        start = 1'bx;
        bits  = 'x;
        wait_send_entry(got);
        if (!got) return;
        repeat (HALF) @(negedge clk);
        start = ps2_data_in;
        for (int i = 0; i < 10; i++) dev_pulse(bits[i]);
        if (ack) dev_data = 1'b0;
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        if (ack) begin
            @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_result(input int budget, output bit seen, output logic d,
                               output logic n, output logic t, output logic oe,
                               output logic rdy, output logic after);
        seen = 1'b0; d = 1'b0; n = 1'b0; t = 1'b0; oe = 1'b1; rdy = 1'b0; after = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1 || timeout === 1'b1) begin
                seen = 1'b1;
                d = done; n = nack; t = timeout;
                oe = ps2_clk_oe | ps2_data_oe;
                rdy = tx_ready;
                break;
            end
        end
        @(negedge clk);
        after = done | nack | timeout;
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); else n_pass++;
        n_checks++; if (ps2_data_oe !== 1'b0) $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); else n_pass++;
        n_checks++; if ({done, nack, timeout} !== 3'b000) $display("FAIL reset_pulses: got %b want 000", {done, nack, timeout}); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", tx_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_inhibit();
        int i0, r0, p0;
        bit got, seen;
        logic start, d, n, t, oe, rdy, after;
        logic [9:0] bits;
        i0 = inhib_cyc; r0 = rts_cyc; p0 = phases;
        send_byte(8'h00);
        device_frame(1'b1, got, start, bits);
        wait_result(200, seen, d, n, t, oe, rdy, after);
        n_checks++; if (got !== 1'b1) $display("FAIL inh_rts_seen: got %b want 1", got); else n_pass++;
        n_checks++; if (inhib_cyc - i0 !== INH) $display("FAIL inh_cycles: got %0d want %0d", inhib_cyc - i0, INH); else n_pass++;
        n_checks++; if (rts_cyc - r0 !== 1) $display("FAIL inh_rts_cycles: got %0d want 1", rts_cyc - r0); else n_pass++;
        n_checks++; if (phases - p0 !== 1) $display("FAIL inh_phases: got %0d want 1", phases - p0); else n_pass++;
        n_checks++; if (start !== 1'b0) $display("FAIL inh_start: got %b want 0", start); else n_pass++;
        n_checks++; if (bits !== model_frame(8'h00)) $display("FAIL inh_frame: got %b want %b", bits, model_frame(8'h00)); else n_pass++;
        n_checks++; if ({seen, d, n} !== 3'b110) $display("FAIL inh_done: got seen/done/nack %b want 110", {seen, d, n}); else n_pass++;
    endtask

    task automatic test_set_led();
        bit got, seen;
        logic start, d, n, t, oe, rdy, after;
        logic [9:0] bits;
        int d0;
        d0 = done_cnt;
        send_byte(PS2_CMD_SET_LED);
        device_frame(1'b1, got, start, bits);
        wait_result(200, seen, d, n, t, oe, rdy, after);
        n_checks++; if (bits !== model_frame(PS2_CMD_SET_LED)) $display("FAIL led_frame: got %b want %b", bits, model_frame(PS2_CMD_SET_LED)); else n_pass++;
        n_checks++; if ({seen, d, n, t} !== 4'b1100) $display("FAIL led_result: got seen/done/nack/to %b want 1100", {seen, d, n, t}); else n_pass++;
        n_checks++; if (oe !== 1'b0) $display("FAIL led_oe_at_done: got %b want 0", oe); else n_pass++;
        n_checks++; if ({after, busy} !== 2'b00) $display("FAIL led_after: got pulse/busy %b want 00", {after, busy}); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL led_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_random_bytes();
        bit got, seen;
        logic start, d, n, t, oe, rdy, after;
        logic [9:0] bits;
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            send_byte(b);
            device_frame(1'b1, got, start, bits);
            wait_result(200, seen, d, n, t, oe, rdy, after);
            n_checks++; if ({start, bits} !== {1'b0, model_frame(b)}) $display("FAIL rand_frame[%0d] byte %h: got %b want %b", k, b, {start, bits}, {1'b0, model_frame(b)}); else n_pass++;
            n_checks++; if ({seen, d, n, t} !== 4'b1100) $display("FAIL rand_result[%0d]: got %b want 1100", k, {seen, d, n, t}); else n_pass++;
        end
    endtask

    task automatic test_nack();
        bit got, seen;
        logic start, d, n, t, oe, rdy, after;
        logic [9:0] bits;
        int d0, p0;
        d0 = done_cnt; p0 = phases;
        send_byte(PS2_CMD_RESET);
        device_frame(1'b0, got, start, bits);
        wait_result(200, seen, d, n, t, oe, rdy, after);
        n_checks++; if (bits !== model_frame(PS2_CMD_RESET)) $display("FAIL nack_frame: got %b want %b", bits, model_frame(PS2_CMD_RESET)); else n_pass++;
        n_checks++; if ({seen, d, n, t} !== 4'b1110) $display("FAIL nack_result: got seen/done/nack/to %b want 1110", {seen, d, n, t}); else n_pass++;
        n_checks++; if (oe !== 1'b0) $display("FAIL nack_oe: got %b want 0", oe); else n_pass++;
        n_checks++; if (phases - p0 !== 1) $display("FAIL nack_phases: got %0d want 1", phases - p0); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL nack_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_retry();
        bit got, seen;
        logic start, d, n, t, oe, rdy, after;
        logic [9:0] bits;
        int d0, p0;
        d0 = done_cnt; p0 = phases;
        send_byte(PS2_CMD_RESET);
        for (int k = 0; k < MAXR; k++) begin
            device_frame(1'b0, got, start, bits);
            n_checks++; if (bits !== model_frame(PS2_CMD_RESET)) $display("FAIL retry_frame[%0d]: got %b want %b", k, bits, model_frame(PS2_CMD_RESET)); else n_pass++;
        end
        n_checks++; if ({busy, done_cnt - d0} !== {1'b1, 32'sd0}) $display("FAIL retry_busy_mid: got busy %b done %0d want 1 0", busy, done_cnt - d0); else n_pass++;
        device_frame(1'b1, got, start, bits);
        wait_result(300, seen, d, n, t, oe, rdy, after);
        n_checks++; if ({seen, d, n, t} !== 4'b1100) $display("FAIL retry_result: got seen/done/nack/to %b want 1100", {seen, d, n, t}); else n_pass++;
        n_checks++; if (phases - p0 !== MAXR + 1) $display("FAIL retry_phases: got %0d want %0d", phases - p0, MAXR + 1); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL retry_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_timeout();
        bit seen;
        logic d, n, t, oe, rdy, after;
        int d0, p0, tries;
        tries = 1;
`ifdef PS2_TX_RETRY_EN
        tries = MAXR + 1;
`endif
        d0 = done_cnt; p0 = phases;
        send_byte(8'h55);
        wait_result((TMO + INH + 50) * tries, seen, d, n, t, oe, rdy, after);
        n_checks++; if ({seen, t, d, n} !== 4'b1100) $display("FAIL to_result: got seen/to/done/nack %b want 1100", {seen, t, d, n}); else n_pass++;
        n_checks++; if ({rdy, oe} !== 2'b10) $display("FAIL to_ready_oe: got %b want 10", {rdy, oe}); else n_pass++;
        n_checks++; if (last_to - (last_rts + 1) !== TMO) $display("FAIL to_latency: got %0d want %0d", last_to - (last_rts + 1), TMO); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL to_no_done: got %0d want 0", done_cnt - d0); else n_pass++;
        n_checks++; if (phases - p0 !== tries) $display("FAIL to_phases: got %0d want %0d", phases - p0, tries); else n_pass++;
        n_checks++; if (after !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", after); else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        bit got, seen;
        logic start, d, n, t, oe, rdy, after, s;
        logic [9:0] bits;
        int d0, t0;
        send_byte(8'h96);
        wait_send_entry(got);
        n_checks++; if (got !== 1'b1) $display("FAIL mid_rts_seen: got %b want 1", got); else n_pass++;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < 4; k++) dev_pulse(s);
        d0 = done_cnt; t0 = to_cnt;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) $display("FAIL mid_release: got clk_oe/data_oe/ready %b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); else n_pass++;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if ({done_cnt - d0, to_cnt - t0} !== {32'sd0, 32'sd0}) $display("FAIL mid_no_pulse: got done %0d to %0d want 0 0", done_cnt - d0, to_cnt - t0); else n_pass++;
        send_byte(PS2_CMD_ENABLE);
        device_frame(1'b1, got, start, bits);
        wait_result(200, seen, d, n, t, oe, rdy, after);
        n_checks++; if ({start, bits} !== {1'b0, model_frame(PS2_CMD_ENABLE)}) $display("FAIL mid_f4_frame: got %b want %b", {start, bits}, {1'b0, model_frame(PS2_CMD_ENABLE)}); else n_pass++;
        n_checks++; if ({seen, d, n, t} !== 4'b1100) $display("FAIL mid_f4_result: got %b want 1100", {seen, d, n, t}); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        bit got, seen;
        logic start, d, n, t, oe, rdy, after;
        logic [9:0] bits;
        logic [7:0] b1, b2;
        int d0, p0;
        d0 = done_cnt; p0 = phases;
        b1 = 8'($urandom);
        b2 = ~b1;
        send_byte(b1);
        repeat (20) @(negedge clk);
        tx_data  = b2;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        device_frame(1'b1, got, start, bits);
        wait_result(200, seen, d, n, t, oe, rdy, after);
        n_checks++; if (bits !== model_frame(b1)) $display("FAIL busy_frame: got %b want %b", bits, model_frame(b1)); else n_pass++;
        repeat (INH * 3) @(negedge clk);
        n_checks++; if (phases - p0 !== 1) $display("FAIL busy_single_frame: got %0d phases want 1", phases - p0); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL busy_idle_after: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_inhibit();
        test_set_led();
        test_random_bytes();
`ifdef PS2_TX_RETRY_EN
        test_retry();
`else
        test_nack();
`endif
        test_timeout();
        test_reset_mid_send();
        test_busy_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
